// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell, LSB first, start/busy/done handshake
// Optional signed-overflow output ovf enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             s, co;
  logic [WIDTH-1:0] r_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    s  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    co = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    // Shift-then-insert keeps the WIDTH=1 case free of an empty slice.
    r_next = r_sh_q >> 1;
    r_next[WIDTH-1] = s;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = r_next;
        c_d    = co;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = r_next;
          cout_d  = co;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB during the final bit.
          ovf_d   = c_q ^ co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
